counter_access_arbiter: RTL

//  Owns the user-project count register and arbitrates its single update port between two requesters:
//  the Wishbone slave (read/byte-write) and a Logic Analyzer masked-load request.

---
 rtl/counter_access_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/counter_access_arbiter.sv
// Owns the user-project count register and arbitrates its single update port
// between the Wishbone slave and a Logic Analyzer masked-load request.
module counter_access_arbiter #(
  parameter int BITS = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_req_i,
  input  logic [BITS-1:0] la_mask_i,
  input  logic [BITS-1:0] la_data_i,
  output logic            la_ack_o,
  input  logic            count_en_i,
  output logic [BITS-1:0] count_o,
  output logic [1:0]      grant_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {IDLE, GNT_WB, ACK_WB, GNT_LA, ACK_LA} state_t;

  state_t          state;
  logic            la_req_q;
  logic            la_pend;
  logic            last_la;
  logic            wb_req;
  logic            la_rise;
  logic [31:0]     count_ext;
  logic [31:0]     lane_mask;
  logic [31:0]     wb_merged;
  logic [BITS-1:0] la_merged;

  assign wb_req    = wbs_cyc_i & wbs_stb_i;
  assign la_rise   = la_req_i & ~la_req_q;
  assign la_merged = (count_o & ~la_mask_i) | (la_data_i & la_mask_i);

  // The count is widened to the 32-bit bus so lanes above BITS read back as zero.
  always_comb begin
    count_ext = '0;
    count_ext[BITS-1:0] = count_o;
    lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                 {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    wb_merged = (count_ext & ~lane_mask) | (wbs_dat_i & lane_mask);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      count_o   <= '0;
      wbs_ack_o <= 1'b0;
      la_ack_o  <= 1'b0;
      wbs_dat_o <= '0;
      grant_o   <= 2'b00;
      busy_o    <= 1'b0;
      la_pend   <= 1'b0;
      la_req_q  <= 1'b0;
      last_la   <= 1'b1;
    end else begin
      la_req_q  <= la_req_i;
      wbs_ack_o <= 1'b0;
      la_ack_o  <= 1'b0;
      if (count_en_i) count_o <= count_o + 1'b1;

      case (state)
        IDLE: begin
          // On a tie the requester that was not served last wins.
          if (wb_req && (!la_pend || last_la)) begin
            state   <= GNT_WB;
            grant_o <= 2'b01;
            busy_o  <= 1'b1;
          end else if (la_pend) begin
            state   <= GNT_LA;
            grant_o <= 2'b10;
            busy_o  <= 1'b1;
            la_pend <= 1'b0;
          end
        end
        GNT_WB: begin
          if (!wbs_cyc_i) begin
            state   <= IDLE;
            grant_o <= 2'b00;
            busy_o  <= 1'b0;
          end else begin
            wbs_dat_o <= count_ext;
            count_o   <= wbs_we_i ? wb_merged[BITS-1:0] : count_o;
            last_la   <= 1'b0;
            wbs_ack_o <= 1'b1;
            state     <= ACK_WB;
          end
        end
        GNT_LA: begin
          count_o  <= la_merged;
          last_la  <= 1'b1;
          la_ack_o <= 1'b1;
          state    <= ACK_LA;
        end
        ACK_WB, ACK_LA: begin
          state   <= IDLE;
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
        end
      endcase

      // A new rising edge must survive the clear done when LA is granted.
      if (la_rise) la_pend <= 1'b1;
    end
  end

endmodule
